// File: rtl/sdram_ctrl_arb.sv
// rtl/sdram_ctrl_arb.sv - N-port SDRAM request arbiter with in-order response tag routing
module sdram_ctrl_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_LEN   = DATA_WIDTH / 8,
    parameter int DEPTH      = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*WORD_LEN-1:0]    m_wr,
    input  logic [NUM_PORTS-1:0]             m_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_write_data,
    output logic [NUM_PORTS-1:0]             m_rdy,
    output logic [NUM_PORTS-1:0]             m_rvalid,
    output logic [NUM_PORTS-1:0]             m_wvalid,
    output logic [NUM_PORTS-1:0]             m_error,
    output logic [DATA_WIDTH-1:0]            m_read_data,
    output logic [WORD_LEN-1:0]              s_wr,
    output logic                             s_rd,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_write_data,
    input  logic                             s_rdy,
    input  logic                             s_rvalid,
    input  logic                             s_wvalid,
    input  logic                             s_error,
    input  logic [DATA_WIDTH-1:0]            s_read_data,
    output logic                             orphan
);

    localparam int TAG_W = $clog2(NUM_PORTS);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_PORTS-1:0] req;
    logic [TAG_W-1:0]     grant;
    logic                 grant_valid;
    logic [TAG_W-1:0]     rr_ptr;
    logic                 full;
    logic                 fwd;
    logic                 accept;
    logic                 resp;
    logic                 pop;
    logic [TAG_W-1:0]     head;

    logic [TAG_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    // A port is requesting when it asks for a read or any byte of a write
    always_comb begin
        req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req[p] = m_rd[p] | (|m_wr[p*WORD_LEN +: WORD_LEN]);
        end
    end

    // Pick the winner; scanning downward lets the lowest-ranked candidate overwrite the others
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (ARB_MODE == 0) begin
                idx = (int'(rr_ptr) + i) % NUM_PORTS;
            end else begin
                idx = i;
            end
            if (req[idx]) begin
                grant       = TAG_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    assign full   = (count == CNT_W'(DEPTH));
    assign fwd    = grant_valid & ~full & ~rst;
    assign accept = fwd & s_rdy;
    assign resp   = s_rvalid | s_wvalid;
    assign pop    = resp & (count != '0) & ~rst;
    assign head   = mem[rd_ptr];

    assign m_read_data = s_read_data;

    // Zero-latency forwarding of the granted port onto the controller side
    always_comb begin
        s_wr         = '0;
        s_rd         = 1'b0;
        s_addr       = '0;
        s_write_data = '0;
        if (fwd) begin
            s_wr         = m_wr[grant*WORD_LEN +: WORD_LEN];
            s_rd         = m_rd[grant];
            s_addr       = m_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
            s_write_data = m_write_data[grant*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Handshake back to the winner, response steered to the oldest outstanding tag
    always_comb begin
        m_rdy    = '0;
        m_rvalid = '0;
        m_wvalid = '0;
        m_error  = '0;
        if (accept) begin
            m_rdy[grant] = 1'b1;
        end
        if (pop) begin
            m_rvalid[head] = s_rvalid;
            m_wvalid[head] = s_wvalid;
            m_error[head]  = s_error;
        end
    end

    // Tag storage carries no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= grant;
        end
    end

    // Tag FIFO pointers/occupancy, round-robin pointer and sticky orphan flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
            orphan <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (ARB_MODE == 0) begin
                    rr_ptr <= (grant == TAG_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
            if (resp && (count == '0)) begin
                orphan <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sdram_ctrl_arb.md
Name: sdram_ctrl_arb

Overview:
- N-port arbiter that merges several sdram_ctrl_if manager-side request streams onto one controller port.
- Requests are granted round-robin or by fixed priority.
- Controller is pipelined: accepted requests are tagged in an in-order tag FIFO. Each rvalid/wvalid response is routed back to the originating port.
- Sits between CPU/DMA/video clients and the single SDRAM controller.

Parameters:
- NUM_PORTS, 4, number of manager ports (>=2)
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, read/write data width
- WORD_LEN, DATA_WIDTH/8, byte-enable width of wr
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests (tag FIFO depth, power of 2)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- m_wr  input  NUM_PORTS*WORD_LEN  per-port byte write enables; slice p = [p*WORD_LEN +: WORD_LEN]
- m_rd  input  NUM_PORTS  per-port read request
- m_addr  input  NUM_PORTS*ADDR_WIDTH  per-port address
- m_write_data  input  NUM_PORTS*DATA_WIDTH  per-port write data
- m_rdy  output  NUM_PORTS  per-port request accepted this cycle
- m_rvalid  output  NUM_PORTS  per-port read data valid
- m_wvalid  output  NUM_PORTS  per-port write complete
- m_error  output  NUM_PORTS  per-port error, qualifies m_rvalid/m_wvalid
- m_read_data  output  DATA_WIDTH  read data, broadcast to all ports, qualified by m_rvalid
- s_wr  output  WORD_LEN  to controller
- s_rd  output  1  to controller
- s_addr  output  ADDR_WIDTH  to controller
- s_write_data  output  DATA_WIDTH  to controller
- s_rdy  input  1  from controller
- s_rvalid  input  1  from controller
- s_wvalid  input  1  from controller
- s_error  input  1  from controller
- s_read_data  input  DATA_WIDTH  from controller
- orphan  output  1  sticky: a response arrived with an empty tag FIFO

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Port request: port p requests when m_rd[p] | (|m_wr slice p). A port holds its request stable until its m_rdy is seen. Read and write in the same cycle from one port is illegal; the bench flags it as an assertion.
- Grant (combinational each cycle):
  - ARB_MODE 0: first requesting port at or after rr_ptr, searching upward with wrap from NUM_PORTS-1 to 0.
  - ARB_MODE 1: lowest-index requesting port.
- Forwarding: granted port's wr/rd/addr/write_data drive s_* with zero latency. With no requester, or while full, or during rst: s_rd=0, s_wr=0, and s_addr/s_write_data are don't-care (drive 0).
- Acceptance:
  - accept = grant_valid & ~full & s_rdy & ~rst.
  - m_rdy[g] = accept; all other m_rdy bits = 0.
  - On accept: push g into the tag FIFO. ARB_MODE 0 also sets rr_ptr <= (g+1) mod NUM_PORTS.
- Tag FIFO:
  - DEPTH entries of clog2(NUM_PORTS) bits.
  - count width clog2(DEPTH+1); full = (count==DEPTH).
  - Pointers wrap modulo DEPTH.
  - Full blocks acceptance even if a pop occurs the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Response:
  - resp = s_rvalid | s_wvalid (the controller never asserts both).
  - If count>0: pop the head tag h and drive m_rvalid[h]=s_rvalid, m_wvalid[h]=s_wvalid, m_error[h]=s_error in the same cycle. All other bits are 0.
  - m_read_data = s_read_data always.
- Orphan: a response with count==0 produces no m_* pulse, sets orphan=1, and orphan holds until rst.
- Reset values:
  - rr_ptr=0, count=0, FIFO pointers=0, orphan=0.
  - While rst=1: m_rdy, m_rvalid, m_wvalid, m_error all 0.
- Reset mid-operation: outstanding tags are discarded. Any later responses to pre-reset requests count as orphans.
- Ordering: responses are assumed in acceptance order (controller guarantee). No reordering is done.

Test Plan:
- NUM_PORTS=4, ARB_MODE 0, ports 0..3 all read continuously, s_rdy=1, immediate s_rvalid -> grants 0,1,2,3,0,... one per cycle; m_rvalid pulses return to the same sequence with s_read_data passed through.
- ARB_MODE 1, ports 1 and 3 request continuously -> port 1 is granted every cycle, port 3 never is. Drop port 1 -> port 3 is granted the next cycle.
- DEPTH=4, s_rdy=1, no responses, port 2 issues 6 writes -> exactly 4 m_rdy pulses, then s_wr=0 and full stays 1. One s_wvalid pops a tag -> m_wvalid[2]=1, and the 5th write is accepted the cycle after.
- Full FIFO with simultaneous s_rvalid and a pending request -> request is not accepted that cycle; it is accepted next cycle; count stays 4.
- Port 0 write (tag 0) accepted, then port 1 read (tag 1); controller returns s_wvalid with s_error=1, then s_rvalid data 0xDEADBEEF -> m_wvalid[0]=1 and m_error[0]=1, then m_rvalid[1]=1 with m_read_data=0xDEADBEEF.
- 2 requests outstanding, rst pulsed for 1 cycle, then 2 s_rvalid arrive -> no m_rvalid pulses, orphan=1, rr_ptr=0, and the next request from port 3 is accepted normally.
